fetch_queue: RTL and testbench

Instruction-fetch stage that sits directly upstream of the control decoder and register file. It owns the fetch address presented to the instruction ROM and buffers fetched 9-bit instructions, each tagged with its PC, in a small FIFO. It releases them to decode through a valid/ready handshake and flushes and redirects on taken jumps/branches. This decouples ROM addressing from decode stalls and gives the core a single place for redirect and halt handling.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetchq_fifo.sv | 83 ++++++++
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and default widths, also used by the decoder and ROM.
package fetch_queue_pkg;

    localparam int IW_DEF    = 9;
    localparam int AW_DEF    = 10;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [IW_DEF-1:0] inst;
        logic [AW_DEF-1:0] pc;
    } fetch_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of fetched entries with wrapping pointers, occupancy count and sync flush.
module fetchq_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});
    assign rdata = mem_r[rd_ptr_r];

    // Qualify requests: flush discards both, a full queue accepts a write only alongside a read
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && !empty;
            do_push_s = push && (!full || do_pop_s);
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the ROM address, buffers {inst, pc} entries, handles redirect/halt.
// Optional fetch/flush statistics counters are enabled with FETCHQ_STATS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          init,
    output logic [AW-1:0] fetch_addr,
    input  logic [IW-1:0] rom_data,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt_req,
    output logic          out_valid,
    output logic [IW-1:0] out_inst,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready,
    output logic          halted
`ifdef FETCHQ_STATS_EN
    ,
    output logic [15:0]   fetch_ct,
    output logic [15:0]   flush_ct
`endif
);

    localparam int EW = IW + AW;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1'b1);

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [AW-1:0] fetch_addr_r;
    logic          flush_s;
    logic          pop_s;
    logic          push_s;
    logic          full_s;
    logic          empty_s;
    logic [EW-1:0] head_s;

    assign flush_s = init | redirect_en;
    assign pop_s   = !empty_s && out_ready;
    // halt_req suppresses the push at the very edge it is sampled
    assign push_s  = (state_r == RUN) && !halt_req && (!full_s || pop_s) && !flush_s;

    fetchq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .flush   (flush_s),
        .push    (push_s),
        .pop     (pop_s),
        .wdata   ({rom_data, fetch_addr_r}),
        .rdata   (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign fetch_addr = fetch_addr_r;
    assign out_valid  = !empty_s;
    assign out_inst   = head_s[EW-1:AW];
    assign out_pc     = head_s[AW-1:0];
    assign halted     = (state_r == HALT) && empty_s;

    // Next state: init restarts, halt_req latches HALT until init or reset
    always_comb begin
        state_nxt_s = state_r;
        if (init) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN:     state_nxt_s = halt_req ? HALT : RUN;
                HALT:    state_nxt_s = HALT;
                default: state_nxt_s = RUN;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch address: restart, redirect target, or advance with each accepted push
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr_r <= {AW{1'b0}};
        end else if (init) begin
            fetch_addr_r <= {AW{1'b0}};
        end else if (redirect_en) begin
            fetch_addr_r <= redirect_pc;
        end else if (push_s) begin
            fetch_addr_r <= fetch_addr_r + ADDR_ONE;
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [15:0] fetch_ct_r;
    logic [15:0] flush_ct_r;

    // Saturating push and redirect counters
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ct_r <= 16'd0;
            flush_ct_r <= 16'd0;
        end else if (init) begin
            fetch_ct_r <= 16'd0;
            flush_ct_r <= 16'd0;
        end else begin
            if (push_s) begin
                fetch_ct_r <= sat_inc16(fetch_ct_r);
            end
            if (redirect_en) begin
                flush_ct_r <= sat_inc16(flush_ct_r);
            end
        end
    end

    assign fetch_ct = fetch_ct_r;
    assign flush_ct = flush_ct_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level model predicts deliveries, a monitor checks them.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       init = 1'b0;
    logic [9:0] fetch_addr;
    logic [8:0] rom_data;
    logic       redirect_en = 1'b0;
    logic [9:0] redirect_pc = 10'd0;
    logic       halt_req = 1'b0;
    logic       out_valid;
    logic [8:0] out_inst;
    logic [9:0] out_pc;
    logic       out_ready = 1'b0;
    logic       halted;
`ifdef FETCHQ_STATS_EN
    logic [15:0] fetch_ct;
    logic [15:0] flush_ct;
`endif

    int pass_ct = 0;
    int total_ct = 0;

    // Reference model: pending entries in delivery order, next fetch PC, halt flag, stats
    fetch_entry_t mq[$];
    logic [9:0]   m_pc = 10'd0;
    logic         m_halt = 1'b0;
    int           m_fcnt = 0;
    int           m_rcnt = 0;

    always #5 CLK = ~CLK;

    function automatic logic [8:0] rom_f(input logic [9:0] a);
        logic [9:0] t;
        t = a + 10'h010;
        return t[8:0];
    endfunction

    assign rom_data = rom_f(fetch_addr);

    fetch_queue dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .init        (init),
        .fetch_addr  (fetch_addr),
        .rom_data    (rom_data),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .halted      (halted)
`ifdef FETCHQ_STATS_EN
        ,
        .fetch_ct    (fetch_ct),
        .flush_ct    (flush_ct)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_ct++;
        if (act === exp) begin
            pass_ct++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at each edge, from the inputs the DUT samples there
    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_pc   = 10'd0;
            m_halt = 1'b0;
            m_fcnt = 0;
            m_rcnt = 0;
        end else if (init) begin
            mq.delete();
            m_pc   = 10'd0;
            m_halt = 1'b0;
            m_fcnt = 0;
            m_rcnt = 0;
        end else if (redirect_en) begin
            mq.delete();
            m_pc = redirect_pc;
            if (m_rcnt < 65535) m_rcnt++;
            if (halt_req) m_halt = 1'b1;
        end else begin
            // mq already reflects this edge's pop (done by the monitor)
            if (!m_halt && !halt_req && mq.size() < DEPTH) begin
                mq.push_back('{inst: rom_f(m_pc), pc: m_pc});
                m_pc = m_pc + 10'd1;
                if (m_fcnt < 65535) m_fcnt++;
            end
            if (halt_req) m_halt = 1'b1;
        end
    end

    // Monitor: compare visible outputs mid-cycle, retire the head on a handshake
    always @(negedge CLK) begin
        chk("out_valid", out_valid, (mq.size() != 0));
        chk("halted", halted, (m_halt && mq.size() == 0));
        chk("fetch_addr", fetch_addr, m_pc);
`ifdef FETCHQ_STATS_EN
        chk("fetch_ct", fetch_ct, m_fcnt);
        chk("flush_ct", flush_ct, m_rcnt);
`endif
        if (out_valid && mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
            if (out_ready) void'(mq.pop_front());
        end
    end

    task automatic drive(input logic i, input logic rdy, input logic rd, input logic [9:0] rp,
                         input logic h, input int n);
        init        = i;
        out_ready   = rdy;
        redirect_en = rd;
        redirect_pc = rp;
        halt_req    = h;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_pc", out_pc, 10'd0);
        reset_n = 1'b1;
        // streaming with decode always ready
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10);
        // fill while stalled, then drain
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 8);
        chk("full_fetch_addr", fetch_addr, 10'd4);
        chk("full_head_pc", out_pc, 10'd0);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10);
        // redirect while full and popping
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 5);
        drive(1'b0, 1'b1, 1'b1, 10'h200, 1'b0, 1);
        chk("redirect_empty", out_valid, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        chk("redirect_target_pc", out_pc, 10'h200);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 5);
        // address wrap
        drive(1'b0, 1'b1, 1'b1, 10'h3FE, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 6);
        // halt with two entries queued, drain, restart
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 2);
        chk("halted_after_drain", halted, 1'b1);
        chk("halt_fetch_addr", fetch_addr, 10'd2);
        drive(1'b0, 1'b1, 1'b1, 10'h123, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        chk("restart_pc", out_pc, 10'd0);
        // ten pushes and two redirects
        drive(1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b1, 10'h050, 1'b0, 2);
        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 6), 10'($urandom), ($urandom_range(0, 99) < 2), 1);
        end
        // asynchronous reset mid-run
        drive(1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 3);
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_addr", fetch_addr, 10'd0);
`ifdef FETCHQ_STATS_EN
        chk("async_reset_fetch_ct", fetch_ct, 16'd0);
        chk("async_reset_flush_ct", flush_ct, 16'd0);
`endif
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 2);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1);
        chk("post_reset_first_pc", out_pc, 10'd0);
        drive(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 5);
        $display("%0d/%0d checks passed", pass_ct, total_ct);
        $finish;
    end

endmodule
